// File: rtl/mod_tx_pkg.sv
// Shared definitions for the modulator transmit arbiter: FSM encoding,
// grant-id width and the byte/nibble mode values understood by data_trans_FIFO_mod.
package mod_tx_pkg;

    localparam int GID_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic MODE_NIBBLE = 1'b0;
    localparam logic MODE_BYTE   = 1'b1;

endpackage

// File: rtl/mod_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted valid index at or after ptr, wrapping.
module rr_pick
    import mod_tx_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [GID_W-1:0] ptr,
    output logic [GID_W-1:0] winner,
    output logic             any
);

    always_comb begin
        winner = '0;
        any    = 1'b0;
        // Scan from the farthest offset back towards ptr so the nearest valid index is written last.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (valid[j] && (j == (int'(ptr) + k) % N_REQ)) begin
                    winner = GID_W'(j);
                    any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mod_tx_arbiter.sv
// Frame-level round-robin scheduler sharing the data_trans_FIFO_mod byte port between
// N_REQ requesters, with a one-entry output slice, inter-frame gap and length cut-off.
module mod_tx_arbiter
    import mod_tx_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int GAP_CYC = 4,
    parameter int MAX_LEN = 64
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_byte,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ready,
    output logic [7:0]           fifo_data,
    output logic                 fifo_start,
    output logic                 fifo_byte,
    input  logic                 fifo_full,
    output logic [GID_W-1:0]     grant_id,
    output logic                 busy,
    output logic                 len_err,
    output logic [1:0]           dbg_state
);

    // Handshakes: a requester byte moves when req_valid[i] & req_ready[i] at a rising edge;
    // a slice byte moves into the modulator FIFO when fifo_start & !fifo_full at a rising edge.

    state_t             r_state;
    state_t             w_state_nxt;
    logic [GID_W-1:0]   r_rr_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic               r_mode;
    logic [7:0]         r_len_cnt;
    logic [7:0]         r_gap_cnt;
    logic [7:0]         r_fifo_data;
    logic               r_fifo_start;
    logic               r_fifo_byte;
    logic               r_len_err;

    logic [GID_W-1:0]   w_winner;
    logic               w_any;
    logic [N_REQ-1:0]   w_gnt_oh;
    logic [N_REQ-1:0]   w_win_oh;
    logic [7:0]         w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_slice_free;
    logic               w_accept;
    logic               w_hit_max;
    logic               w_frame_end;
    logic               w_cut;

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .valid  (req_valid),
        .ptr    (r_rr_ptr),
        .winner (w_winner),
        .any    (w_any)
    );

    assign w_gnt_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << r_grant_id;
    assign w_win_oh     = {{(N_REQ-1){1'b0}}, 1'b1} << w_winner;
    assign w_sel_valid  = |(req_valid & w_gnt_oh);
    assign w_sel_last   = |(req_last & w_gnt_oh);

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (r_grant_id == GID_W'(i)) begin
                w_sel_data = req_data[8*i +: 8];
            end
        end
    end

    // The slice can take a byte if it is empty or is being written this very cycle.
    assign w_slice_free = !r_fifo_start || !fifo_full;
    assign w_accept     = (r_state == ST_GRANT) && w_sel_valid && w_slice_free;
    assign w_hit_max    = (r_len_cnt + 8'd1) == 8'(MAX_LEN);
    assign w_frame_end  = w_accept && (w_sel_last || w_hit_max);
    assign w_cut        = w_accept && !w_sel_last && w_hit_max;

    assign req_ready = ((r_state == ST_GRANT) && w_slice_free) ? w_gnt_oh : '0;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
            ST_GRANT: if (w_frame_end) w_state_nxt = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
            ST_GAP:   if (r_gap_cnt <= 8'd1) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_rr_ptr     <= '0;
            r_grant_id   <= '0;
            r_mode       <= MODE_NIBBLE;
            r_len_cnt    <= '0;
            r_gap_cnt    <= '0;
            r_fifo_data  <= '0;
            r_fifo_start <= 1'b0;
            r_fifo_byte  <= MODE_NIBBLE;
            r_len_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_len_err <= w_cut;

            if (r_state == ST_IDLE && w_any) begin
                r_grant_id <= w_winner;
                r_mode     <= |(req_byte & w_win_oh);
                r_len_cnt  <= '0;
                r_rr_ptr   <= (w_winner == GID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
            end else if (w_accept && r_len_cnt < 8'(MAX_LEN)) begin
                r_len_cnt <= r_len_cnt + 8'd1;
            end

            if (w_frame_end) begin
                r_gap_cnt <= 8'(GAP_CYC);
            end else if (r_state == ST_GAP && r_gap_cnt != 8'd0) begin
                r_gap_cnt <= r_gap_cnt - 8'd1;
            end

            if (w_accept) begin
                r_fifo_data  <= w_sel_data;
                r_fifo_start <= 1'b1;
                r_fifo_byte  <= r_mode;
            end else if (r_fifo_start && !fifo_full) begin
                r_fifo_start <= 1'b0;
            end
        end
    end

    assign fifo_data  = r_fifo_data;
    assign fifo_start = r_fifo_start;
    assign fifo_byte  = r_fifo_byte;
    assign grant_id   = r_grant_id;
    assign len_err    = r_len_err;
    assign busy       = (r_state != ST_IDLE) || r_fifo_start;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_mod_tx_arbiter.sv
// Bench for mod_tx_arbiter: instance a (GAP_CYC=4, MAX_LEN=4) carries most scenarios,
// instance b (GAP_CYC=0) covers back-to-back frames with a mode switch.
module tb_mod_tx_arbiter;
    import mod_tx_pkg::*;

    localparam int GAP_A = 4;
    localparam int MAX_A = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic [1:0]  req_valid, req_byte, req_last, req_ready;
    logic [15:0] req_data;
    logic [7:0]  fifo_data;
    logic        fifo_start, fifo_byte, fifo_full, busy, len_err;
    logic [1:0]  grant_id, dbg_state;

    logic [1:0]  b_req_valid, b_req_byte, b_req_last, b_req_ready;
    logic [15:0] b_req_data;
    logic [7:0]  b_fifo_data;
    logic        b_fifo_start, b_fifo_byte, b_fifo_full, b_busy, b_len_err;
    logic [1:0]  b_grant_id, b_dbg_state;

    mod_tx_arbiter #(.N_REQ(2), .GAP_CYC(GAP_A), .MAX_LEN(MAX_A)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_byte(req_byte), .req_last(req_last), .req_ready(req_ready),
        .fifo_data(fifo_data), .fifo_start(fifo_start), .fifo_byte(fifo_byte),
        .fifo_full(fifo_full), .grant_id(grant_id), .busy(busy), .len_err(len_err),
        .dbg_state(dbg_state)
    );

    mod_tx_arbiter #(.N_REQ(2), .GAP_CYC(0), .MAX_LEN(64)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_req_valid), .req_data(b_req_data),
        .req_byte(b_req_byte), .req_last(b_req_last), .req_ready(b_req_ready),
        .fifo_data(b_fifo_data), .fifo_start(b_fifo_start), .fifo_byte(b_fifo_byte),
        .fifo_full(b_fifo_full), .grant_id(b_grant_id), .busy(b_busy), .len_err(b_len_err),
        .dbg_state(b_dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    logic [8:0] exp_q[$];
    logic [8:0] src0_q[$];
    logic [8:0] src1_q[$];
    int         acc_cyc[$];
    int         acc_id[$];
    int         wr_cyc[$];
    int         err_cyc[$];
    logic [1:0] err_state[$];
    logic [1:0] acc_flag;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor (dut_a) ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            if (fifo_start && !fifo_full) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL wr_unexpected: got %h with nothing expected", {fifo_byte, fifo_data});
                end else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    if ({fifo_byte, fifo_data} !== e) begin
                        n_err++;
                        $display("FAIL wr_data: got %h expected %h", {fifo_byte, fifo_data}, e);
                    end
                end
                wr_cyc.push_back(cyc);
            end
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    exp_q.push_back({req_byte[i], req_data[8*i +: 8]});
                    acc_cyc.push_back(cyc);
                    acc_id.push_back(i);
                    acc_flag[i] = 1'b1;
                    n_cmp++;
                    if (grant_id !== 2'(i)) begin
                        n_err++;
                        $display("FAIL grant_id_on_accept: got %0d expected %0d", grant_id, i);
                    end
                end
            end
            if (len_err) begin
                err_cyc.push_back(cyc);
                err_state.push_back(dbg_state);
            end
        end
    end

    // ---------------- requester driver (dut_a) ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (acc_flag[0] && src0_q.size() > 0) void'(src0_q.pop_front());
            if (acc_flag[1] && src1_q.size() > 0) void'(src1_q.pop_front());
            acc_flag = 2'b00;
            req_valid[0]   = (src0_q.size() > 0);
            req_data[7:0]  = (src0_q.size() > 0) ? src0_q[0][7:0] : 8'h00;
            req_last[0]    = (src0_q.size() > 0) ? src0_q[0][8] : 1'b0;
            req_valid[1]   = (src1_q.size() > 0);
            req_data[15:8] = (src1_q.size() > 0) ? src1_q[0][7:0] : 8'h00;
            req_last[1]    = (src1_q.size() > 0) ? src1_q[0][8] : 1'b0;
        end
    end

    task automatic clear_logs();
        acc_cyc.delete(); acc_id.delete(); wr_cyc.delete();
        err_cyc.delete(); err_state.delete();
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        reset_n = 1'b0;
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        acc_flag = 2'b00;
        fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        #2 reset_n = 1'b1;
        clear_logs();
    endtask

    task automatic wait_writes(input int k, input int budget, input string name);
        int t = 0;
        while (wr_cyc.size() < k && t < budget) begin
            @(posedge clk);
            t++;
        end
        n_cmp++;
        if (wr_cyc.size() < k) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d writes required %0d", name, wr_cyc.size(), k);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp += 8;
        if (fifo_data !== 8'h00)  begin n_err++; $display("FAIL rst_fifo_data: got %h required 00", fifo_data); end
        if (fifo_start !== 1'b0)  begin n_err++; $display("FAIL rst_fifo_start: got %b required 0", fifo_start); end
        if (fifo_byte !== 1'b0)   begin n_err++; $display("FAIL rst_fifo_byte: got %b required 0", fifo_byte); end
        if (grant_id !== 2'd0)    begin n_err++; $display("FAIL rst_grant_id: got %0d required 0", grant_id); end
        if (len_err !== 1'b0)     begin n_err++; $display("FAIL rst_len_err: got %b required 0", len_err); end
        if (req_ready !== 2'b00)  begin n_err++; $display("FAIL rst_req_ready: got %b required 00", req_ready); end
        if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy: got %b required 0", busy); end
        if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rst_state: got %0d required 0", dbg_state); end
        #1 reset_n = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        req_byte = 2'b01;
        @(posedge clk); #2;
        src0_q.push_back({1'b0, 8'h12});
        src0_q.push_back({1'b0, 8'h34});
        src0_q.push_back({1'b1, 8'h56});
        src0_q.push_back({1'b1, 8'h78});
        wait_writes(4, 100, "single");
        if (wr_cyc.size() >= 4 && acc_cyc.size() >= 4) begin
            n_cmp += 5;
            if (wr_cyc[0] - acc_cyc[0] != 1) begin n_err++; $display("FAIL single_latency: got %0d required 1", wr_cyc[0] - acc_cyc[0]); end
            if (wr_cyc[1] - wr_cyc[0] != 1)  begin n_err++; $display("FAIL single_b2b_1: got %0d required 1", wr_cyc[1] - wr_cyc[0]); end
            if (wr_cyc[2] - wr_cyc[1] != 1)  begin n_err++; $display("FAIL single_b2b_2: got %0d required 1", wr_cyc[2] - wr_cyc[1]); end
            if (acc_cyc[3] - acc_cyc[2] != GAP_A + 2) begin n_err++; $display("FAIL single_gap: got %0d required %0d", acc_cyc[3] - acc_cyc[2], GAP_A + 2); end
            if (exp_q.size() != 0) begin n_err++; $display("FAIL single_leftover: got %0d required 0", exp_q.size()); end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_byte = 2'b01;
        @(posedge clk); #2;
        for (int f = 0; f < 3; f++) begin
            src0_q.push_back({1'b0, 8'(8'h10 + 2*f)});
            src0_q.push_back({1'b1, 8'(8'h11 + 2*f)});
            src1_q.push_back({1'b0, 8'(8'h80 + 2*f)});
            src1_q.push_back({1'b1, 8'(8'h81 + 2*f)});
        end
        wait_writes(12, 300, "rr");
        for (int k = 0; k < 12; k++) begin
            n_cmp++;
            if (k >= acc_id.size()) begin
                n_err++;
                $display("FAIL rr_order_missing: got %0d accepts required 12", acc_id.size());
                break;
            end else if (acc_id[k] != (k / 2) % 2) begin
                n_err++;
                $display("FAIL rr_order: byte %0d got requester %0d required %0d", k, acc_id[k], (k / 2) % 2);
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_byte = 2'b00;
        @(posedge clk); #2;
        src0_q.push_back({1'b0, 8'hC1});
        src0_q.push_back({1'b0, 8'hC2});
        src0_q.push_back({1'b0, 8'hC3});
        src0_q.push_back({1'b1, 8'hC4});
        wait_writes(1, 50, "bp_start");
        #1 fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp += 3;
            if (fifo_start !== 1'b1) begin n_err++; $display("FAIL bp_start_held: got %b required 1", fifo_start); end
            if (exp_q.size() == 0 || fifo_data !== exp_q[0][7:0]) begin
                n_err++;
                $display("FAIL bp_data_held: got %h required %h", fifo_data, (exp_q.size() > 0) ? exp_q[0][7:0] : 8'hxx);
            end
            if (req_ready !== 2'b00) begin n_err++; $display("FAIL bp_ready: got %b required 00", req_ready); end
        end
        @(posedge clk); #1 fifo_full = 1'b0;
        wait_writes(4, 50, "bp_drain");
        n_cmp += 3;
        if (exp_q.size() != 0)   begin n_err++; $display("FAIL bp_leftover: got %0d required 0", exp_q.size()); end
        if (acc_cyc.size() != 4) begin n_err++; $display("FAIL bp_accepts: got %0d required 4", acc_cyc.size()); end
        if (err_cyc.size() != 0) begin n_err++; $display("FAIL bp_len_err: got %0d pulses required 0", err_cyc.size()); end
    endtask

    task automatic test_len_cut();
        do_reset();
        req_byte = 2'b01;
        @(posedge clk); #2;
        for (int b = 1; b <= 6; b++) src0_q.push_back({(b == 6), 8'(8'hD0 + b)});
        wait_writes(6, 200, "cut");
        n_cmp++;
        if (err_cyc.size() != 1) begin
            n_err++;
            $display("FAIL cut_pulses: got %0d required 1", err_cyc.size());
        end else if (acc_cyc.size() >= 6) begin
            n_cmp += 4;
            if (err_cyc[0] != acc_cyc[3] + 1) begin n_err++; $display("FAIL cut_pulse_time: got %0d required %0d", err_cyc[0], acc_cyc[3] + 1); end
            if (err_state[0] !== ST_GAP) begin n_err++; $display("FAIL cut_state: got %0d required %0d", err_state[0], ST_GAP); end
            if (acc_cyc[4] - acc_cyc[3] != GAP_A + 2) begin n_err++; $display("FAIL cut_regrant: got %0d required %0d", acc_cyc[4] - acc_cyc[3], GAP_A + 2); end
            if (acc_cyc[2] - acc_cyc[0] != 2) begin n_err++; $display("FAIL cut_stream: got %0d required 2", acc_cyc[2] - acc_cyc[0]); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_byte = 2'b01;
        @(posedge clk); #2;
        for (int b = 1; b <= 4; b++) src0_q.push_back({(b == 4), 8'(8'hE0 + b)});
        wait_writes(1, 50, "rmid_start");
        #1 fifo_full = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (fifo_start !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL rmid_occupied: got start=%b busy=%b required 1 1", fifo_start, busy); end
        @(posedge clk); #2;
        reset_n = 1'b0;
        src0_q.delete(); src1_q.delete(); exp_q.delete();
        acc_flag = 2'b00;
        fifo_full = 1'b0;
        @(posedge clk); #2 reset_n = 1'b1;
        clear_logs();
        @(negedge clk);
        n_cmp += 7;
        if (fifo_start !== 1'b0)   begin n_err++; $display("FAIL rmid_start: got %b required 0", fifo_start); end
        if (fifo_data !== 8'h00)   begin n_err++; $display("FAIL rmid_data: got %h required 00", fifo_data); end
        if (fifo_byte !== 1'b0)    begin n_err++; $display("FAIL rmid_byte: got %b required 0", fifo_byte); end
        if (grant_id !== 2'd0)     begin n_err++; $display("FAIL rmid_grant: got %0d required 0", grant_id); end
        if (req_ready !== 2'b00)   begin n_err++; $display("FAIL rmid_ready: got %b required 00", req_ready); end
        if (busy !== 1'b0)         begin n_err++; $display("FAIL rmid_busy: got %b required 0", busy); end
        if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_state: got %0d required 0", dbg_state); end
        @(posedge clk); #2;
        src0_q.push_back({1'b1, 8'hF0});
        src1_q.push_back({1'b1, 8'hF1});
        wait_writes(2, 50, "rmid_after");
        n_cmp += 2;
        if (acc_id.size() == 0 || acc_id[0] != 0) begin n_err++; $display("FAIL rmid_rr_ptr: got requester %0d required 0", (acc_id.size() > 0) ? acc_id[0] : -1); end
        if (exp_q.size() != 0) begin n_err++; $display("FAIL rmid_leftover: got %0d required 0", exp_q.size()); end
    endtask

    task automatic test_gap0();
        logic [7:0] d0[2];
        logic [7:0] d1[2];
        logic [8:0] exp_w[4];
        logic [8:0] b_wr[$];
        int         b_acc[$];
        int         k0 = 0;
        int         k1 = 0;
        int         t  = 0;
        logic [1:0] adv;
        d0 = '{8'hA1, 8'hA2};
        d1 = '{8'hB1, 8'hB2};
        exp_w = '{{MODE_NIBBLE, 8'hA1}, {MODE_NIBBLE, 8'hA2}, {MODE_BYTE, 8'hB1}, {MODE_BYTE, 8'hB2}};
        do_reset();
        @(posedge clk); #2;
        b_req_byte = 2'b10;
        while (b_wr.size() < 4 && t < 100) begin
            b_req_valid = {k1 < 2, k0 < 2};
            b_req_data  = {d1[(k1 < 2) ? k1 : 1], d0[(k0 < 2) ? k0 : 1]};
            b_req_last  = {k1 == 1, k0 == 1};
            @(negedge clk);
            adv = b_req_valid & b_req_ready;
            if (b_fifo_start) b_wr.push_back({b_fifo_byte, b_fifo_data});
            if (adv != 2'b00) b_acc.push_back(cyc);
            @(posedge clk); #2;
            if (adv[0]) k0++;
            if (adv[1]) k1++;
            t++;
        end
        b_req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (i >= b_wr.size()) begin
                n_err++;
                $display("FAIL gap0_missing: got %0d writes required 4", b_wr.size());
                break;
            end else if (b_wr[i] !== exp_w[i]) begin
                n_err++;
                $display("FAIL gap0_write%0d: got %h required %h", i, b_wr[i], exp_w[i]);
            end
        end
        n_cmp++;
        if (b_acc.size() < 3 || b_acc[2] - b_acc[1] != 2) begin
            n_err++;
            $display("FAIL gap0_regrant: got %0d required 2", (b_acc.size() >= 3) ? b_acc[2] - b_acc[1] : -1);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp += 4;
        if (b_busy !== 1'b0)         begin n_err++; $display("FAIL gap0_busy: got %b required 0", b_busy); end
        if (b_grant_id !== 2'd1)     begin n_err++; $display("FAIL gap0_grant: got %0d required 1", b_grant_id); end
        if (b_dbg_state !== ST_IDLE) begin n_err++; $display("FAIL gap0_state: got %0d required 0", b_dbg_state); end
        if (b_len_err !== 1'b0)      begin n_err++; $display("FAIL gap0_len_err: got %b required 0", b_len_err); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset_n     = 1'b0;
        req_valid   = 2'b00;
        req_data    = 16'h0000;
        req_byte    = 2'b00;
        req_last    = 2'b00;
        fifo_full   = 1'b0;
        acc_flag    = 2'b00;
        b_req_valid = 2'b00;
        b_req_data  = 16'h0000;
        b_req_byte  = 2'b00;
        b_req_last  = 2'b00;
        b_fifo_full = 1'b0;

        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_len_cut();
        test_reset_mid();
        test_gap0();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mod_tx_arbiter.md
# mod_tx_arbiter

Frame-level scheduler that shares the byte-input port of `data_trans_FIFO_mod` (byte FIFO + 5-bit modulator) between `N_REQ` independent requesters. Grants whole frames round-robin, drives `data_in`/`start`/`byte` through a one-entry registered slice that honours the FIFO `full` back-pressure, inserts a programmable idle gap between frames, and cuts off runaway frames with an error pulse.

## Interface
- `N_REQ`, 2: number of requesters, 2..4.
- `GAP_CYC`, 4: idle cycles inserted after each frame, 0..255.
- `MAX_LEN`, 64: maximum bytes per frame, 1..255.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `req_valid` in N_REQ: requester i has a byte on `req_data[8i+7:8i]`.
- `req_data` in 8*N_REQ: packed request bytes.
- `req_byte` in N_REQ: frame mode; 1 = full byte, 0 = nibble mode; sampled at grant.
- `req_last` in N_REQ: the presented byte ends the frame.
- `req_ready` out N_REQ: byte accepted from requester i when `req_valid[i] & req_ready[i]`.
- `fifo_data` out 8: to modulator `data_in`.
- `fifo_start` out 1: to modulator `start`; byte written when `fifo_start & !fifo_full`.
- `fifo_byte` out 1: to modulator `byte`.
- `fifo_full` in 1: modulator FIFO full.
- `grant_id` out 2: current/last granted requester.
- `busy` out 1: state ≠ IDLE or slice occupied.
- `len_err` out 1: one-cycle pulse on MAX_LEN cut-off.

## Operation
- States: IDLE, GRANT, GAP.
- IDLE: if any `req_valid`, choose first valid index at or after `rr_ptr` (wrapping); register `grant_id`, latch `req_byte[winner]` into mode reg, clear `len_cnt`, `rr_ptr <= winner+1 mod N_REQ`, go GRANT. No valid: stay.
- GRANT: `req_ready[grant_id] = slice_free`, where `slice_free = !fifo_start | !fifo_full`; all other ready bits 0. Accepted byte loads slice (`fifo_data`, `fifo_start=1`, `fifo_byte`=mode), `len_cnt++`.
- Frame end: accepted byte with `req_last`, or accepted byte making `len_cnt == MAX_LEN` without `req_last` (then `len_err` pulses next cycle). Either -> GAP with `gap_cnt = GAP_CYC`; GAP_CYC = 0 -> IDLE directly.
- After cut-off, the requester's remaining bytes form a new frame, arbitrated normally.
- GAP: `gap_cnt--` each cycle; at 1 -> IDLE. No `req_ready` in IDLE/GAP. The slice still drains in GAP.
- Slice: holds data stable while `fifo_start & fifo_full`. Clears `fifo_start` on write unless a new byte loads the same cycle (back-to-back, one byte/cycle).
- `len_cnt` 8-bit, saturates at MAX_LEN. `gap_cnt` 8-bit.

## Timing
- Reset values (synchronous, `reset_n` = 0 at an edge): state IDLE, `rr_ptr`=0, `grant_id`=0, `fifo_data`=0, `fifo_start`=0, `fifo_byte`=0, `len_err`=0, `req_ready`=0, counters 0.
- Reset mid-frame discards the slice byte and grant; requester must resend the frame.
- Arbitration latency: `req_valid` seen in IDLE at edge n -> `req_ready` high in cycle n+1.
- Accept-to-`fifo_start`: 1 cycle. Full throughput 1 byte/cycle while `fifo_full`=0.
- `fifo_full` rising while `fifo_start`=1: byte held, `req_ready` drops the same cycle (combinational).
- Frame-to-frame gap: last accept at n -> next grant decision at n+1+GAP_CYC, first `req_ready` at n+2+GAP_CYC.
- Simultaneous valid from all requesters: strict round-robin per frame; no requester waits more than N_REQ−1 frames.

## Structure
- Shared package `mod_tx_pkg`: state encoding (IDLE=0, GRANT=1, GAP=2), width constant `GID_W`=2, byte/nibble mode constants shared with `data_trans_FIFO_mod`.
- Sub-module `rr_pick`: combinational round-robin priority picker (`valid`, `ptr` -> `winner`, `any`). All else is in the top.

## Test plan
- Single requester 0, 3-byte frame 0x12,0x34,0x56 (last on 0x56), `fifo_full`=0 -> `fifo_start` high 3 consecutive cycles with those bytes, `fifo_byte`=`req_byte`, then 4 idle cycles before next ready.
- Requesters 0 and 1 both valid continuously, 2-byte frames -> grants 0,1,0,1; `grant_id` alternates; never 2 frames in a row to one requester.
- `fifo_full` held high for 5 cycles mid-frame -> `fifo_data` stable 5 cycles, `req_ready`=0, no byte lost or duplicated; resumes on full low.
- MAX_LEN=4, 6-byte frame without last until byte 6 -> `len_err` single pulse after byte 4, GAP, bytes 5-6 sent as a new frame.
- `reset_n` low 1 cycle mid-frame with slice occupied -> next cycle all outputs 0, state IDLE, `rr_ptr`=0.
- GAP_CYC=0, nibble-mode frame (`req_byte`=0) back-to-back with byte-mode frame -> `fifo_byte` switches exactly on the first byte of the second frame; grant gap is 1 cycle.
